traffic_light_controller: RTL

- Master sequencer for a two-road intersection (main street, side street) with a pedestrian walk phase.
- Initiator side of the timer interface: loads the interval onto value, pulses start_timer, and advances state when the timer returns expired.
- Drives the lamp outputs for both roads and the walk lamp.
- Sits above the timer instance in the top level; enable_1Hz goes to the timer only.

---
 rtl/traffic_pkg.sv | 37 +++
 rtl/traffic_light_controller_request_latch.sv | 36 +++
 rtl/traffic_light_controller.sv | 139 +++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection sequencer: state codes, lamp codes,
// interval width and the state-to-lamp decode.
package traffic_pkg;

  localparam int TIMER_W = 4;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  localparam logic [3:0] S_INIT   = 4'd0;
  localparam logic [3:0] S_MG     = 4'd1;
  localparam logic [3:0] S_MG_EXT = 4'd2;
  localparam logic [3:0] S_MY     = 4'd3;
  localparam logic [3:0] S_SG     = 4'd4;
  localparam logic [3:0] S_SG_EXT = 4'd5;
  localparam logic [3:0] S_SY     = 4'd6;
  localparam logic [3:0] S_WALK   = 4'd7;
  localparam logic [3:0] S_CLR    = 4'd8;

  // {main[2:0], side[2:0], walk}
  typedef logic [6:0] lamps_t;

  localparam lamps_t LAMPS_ALL_RED = {LAMP_RED, LAMP_RED, 1'b0};

  function automatic lamps_t lamps_for(input logic [3:0] s);
    case (s)
      S_MG, S_MG_EXT: lamps_for = {LAMP_GRN, LAMP_RED, 1'b0};
      S_MY:           lamps_for = {LAMP_YEL, LAMP_RED, 1'b0};
      S_SG, S_SG_EXT: lamps_for = {LAMP_RED, LAMP_GRN, 1'b0};
      S_SY:           lamps_for = {LAMP_RED, LAMP_YEL, 1'b0};
      S_WALK:         lamps_for = {LAMP_RED, LAMP_RED, 1'b1};
      default:        lamps_for = LAMPS_ALL_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_light_controller_request_latch.sv
// Set/clear request latch; set wins when both arrive in the same cycle.
module request_latch (
  input  logic clock,
  input  logic reset_sync,
  input  logic set_req,
  input  logic clr_req,
  output logic latched
);

  logic latched_q;
  logic latched_d;

  // next-state: set has priority over clear
  always_comb begin
    latched_d = latched_q;
    if (set_req) begin
      latched_d = 1'b1;
    end else if (clr_req) begin
      latched_d = 1'b0;
    end else begin
      latched_d = latched_q;
    end
  end

  // latch register with synchronous active-low reset
  always_ff @(posedge clock) begin
    if (!reset_sync) begin
      latched_q <= 1'b0;
    end else begin
      latched_q <= latched_d;
    end
  end

  assign latched = latched_q;

endmodule

// File: rtl/traffic_light_controller.sv
// Two-road intersection sequencer with pedestrian walk phase.
// Optional all-red clearance phase after each yellow: ALL_RED_CLEAR_EN.
module traffic_light_controller
  import traffic_pkg::*;
#(
  parameter logic [TIMER_W-1:0] T_BASE = 4'd6,
  parameter logic [TIMER_W-1:0] T_EXT  = 4'd3,
  parameter logic [TIMER_W-1:0] T_YEL  = 4'd2
) (
  input  logic               clock,
  input  logic               reset_sync,
  input  logic               sensor,
  input  logic               walk_request,
  input  logic               expired,
  output logic               start_timer,
  output logic [TIMER_W-1:0] value,
  output logic [2:0]         main_lights,
  output logic [2:0]         side_lights,
  output logic               walk
);

  logic [3:0]         state_q, state_d;
  logic               armed_q, armed_d;
  logic               start_timer_q, start_timer_d;
  logic [TIMER_W-1:0] value_q, value_d;
  lamps_t             lamps_q, lamps_d;
  logic               fire_s;
  logic               enter_s;
  logic               walk_pending_s;
  logic               walk_clr_s;

  function automatic logic [TIMER_W-1:0] interval_for(input logic [3:0] s);
    case (s)
      S_MG, S_SG:                 interval_for = T_BASE;
      S_MG_EXT, S_SG_EXT, S_WALK: interval_for = T_EXT;
      S_MY, S_SY:                 interval_for = T_YEL;
      S_CLR:                      interval_for = 4'd1;
      default:                    interval_for = 4'd0;
    endcase
  endfunction

  // An expiry still high from the previous interval must not count while the
  // timer is being reloaded, nor in the cycle right after.
  assign fire_s = expired & armed_q & ~start_timer_q;

`ifdef ALL_RED_CLEAR_EN
  logic from_side_q, from_side_d;

  // remembers which yellow led into the clearance phase
  always_comb begin
    from_side_d = from_side_q;
    if (fire_s && (state_q == S_SY)) begin
      from_side_d = 1'b1;
    end else if (fire_s && (state_q == S_MY)) begin
      from_side_d = 1'b0;
    end else begin
      from_side_d = from_side_q;
    end
  end

  // clearance-origin register
  always_ff @(posedge clock) begin
    if (!reset_sync) begin
      from_side_q <= 1'b0;
    end else begin
      from_side_q <= from_side_d;
    end
  end
`endif

  // state transition logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_INIT:   state_d = S_MG;
      S_MG:     if (fire_s) state_d = sensor ? S_MG_EXT : S_MY; else state_d = state_q;
      S_MG_EXT: if (fire_s) state_d = S_MY; else state_d = state_q;
`ifdef ALL_RED_CLEAR_EN
      S_MY:     if (fire_s) state_d = S_CLR; else state_d = state_q;
      S_SY:     if (fire_s) state_d = S_CLR; else state_d = state_q;
      S_CLR: begin
        if (fire_s) begin
          if (from_side_q) state_d = walk_pending_s ? S_WALK : S_MG;
          else             state_d = S_SG;
        end else begin
          state_d = state_q;
        end
      end
`else
      S_MY:     if (fire_s) state_d = S_SG; else state_d = state_q;
      S_SY:     if (fire_s) state_d = walk_pending_s ? S_WALK : S_MG; else state_d = state_q;
`endif
      S_SG:     if (fire_s) state_d = sensor ? S_SG_EXT : S_SY; else state_d = state_q;
      S_SG_EXT: if (fire_s) state_d = S_SY; else state_d = state_q;
      S_WALK:   if (fire_s) state_d = S_MG; else state_d = state_q;
      default:  state_d = S_INIT;
    endcase
  end

  // output values are decoded from the next state so they line up with it
  always_comb begin
    enter_s       = (state_d != state_q);
    start_timer_d = enter_s;
    value_d       = enter_s ? interval_for(state_d) : value_q;
    lamps_d       = lamps_for(state_d);
    armed_d       = ~start_timer_q;
    walk_clr_s    = enter_s & (state_d == S_WALK);
  end

  // state and registered outputs
  always_ff @(posedge clock) begin
    if (!reset_sync) begin
      state_q       <= S_INIT;
      armed_q       <= 1'b0;
      start_timer_q <= 1'b0;
      value_q       <= 4'd0;
      lamps_q       <= LAMPS_ALL_RED;
    end else begin
      state_q       <= state_d;
      armed_q       <= armed_d;
      start_timer_q <= start_timer_d;
      value_q       <= value_d;
      lamps_q       <= lamps_d;
    end
  end

  request_latch u_walk_latch (
    .clock      (clock),
    .reset_sync (reset_sync),
    .set_req    (walk_request),
    .clr_req    (walk_clr_s),
    .latched    (walk_pending_s)
  );

  assign start_timer = start_timer_q;
  assign value       = value_q;
  assign {main_lights, side_lights, walk} = lamps_q;

endmodule
